// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - shared constants and event bundle for the I2C slave front end
package i2c_slave_pkg;

    localparam logic I2C_IDLE_LEVEL  = 1'b1;
    localparam int   DEF_SYNC_STAGES = 2;
    localparam int   DEF_FILT_LEN    = 3;

    typedef struct packed {
        logic rx_edge;
        logic tx_edge;
        logic start_det;
        logic stop_det;
    } i2c_line_evt_t;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - pad synchroniser chain followed by a consecutive-sample glitch filter
module i2c_line_filter
    import i2c_slave_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN
) (
    input  logic i_pclk,
    input  logic i_presetn,
    input  logic i_pad,
    output logic o_level
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_level  = r_level;

    // The level only follows after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge i_pclk) begin
        if (!i_presetn) begin
            r_sync  <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
            r_cnt   <= '0;
            r_level <= I2C_IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_slave_line_cond.sv
// rtl/i2c_slave_line_cond.sv - SCL/SDA conditioning, edge/START/STOP decode, bus busy; optional I2C_SLAVE_SCL_TIMEOUT_EN
module i2c_slave_line_cond
    import i2c_slave_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic pclk,
    input  logic presetn,
    input  logic scl_pad,
    input  logic sda_pad,
    output logic scl_in,
    output logic sda_in,
    output logic rx_edge,
    output logic tx_edge,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic scl_timeout
);

    logic          w_scl;
    logic          w_sda;
    logic          r_scl_d;
    logic          r_sda_d;
    logic          r_busy;
    logic          w_tmo_clr;
    i2c_line_evt_t w_evt;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .i_pclk    (pclk),
        .i_presetn (presetn),
        .i_pad     (scl_pad),
        .o_level   (w_scl)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .i_pclk    (pclk),
        .i_presetn (presetn),
        .i_pad     (sda_pad),
        .o_level   (w_sda)
    );

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_scl_d <= I2C_IDLE_LEVEL;
            r_sda_d <= I2C_IDLE_LEVEL;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    // START/STOP require SCL stable high across both samples, so a joint SCL/SDA move is ignored.
    assign w_evt.rx_edge   =  w_scl & ~r_scl_d;
    assign w_evt.tx_edge   = ~w_scl &  r_scl_d;
    assign w_evt.start_det =  w_scl &  r_scl_d &  r_sda_d & ~w_sda;
    assign w_evt.stop_det  =  w_scl &  r_scl_d & ~r_sda_d &  w_sda;

`ifdef I2C_SLAVE_SCL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (r_busy && !w_scl) begin
            if (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                r_tmo_cnt <= '0;
                r_timeout <= 1'b1;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                r_timeout <= 1'b0;
            end
        end else begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end
    end

    assign w_tmo_clr   = r_timeout;
    assign scl_timeout = r_timeout;
`else
    assign w_tmo_clr   = 1'b0;
    assign scl_timeout = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_busy <= 1'b0;
        end else if (w_tmo_clr) begin
            r_busy <= 1'b0;
        end else if (w_evt.start_det) begin
            r_busy <= 1'b1;
        end else if (w_evt.stop_det) begin
            r_busy <= 1'b0;
        end
    end

    assign scl_in    = w_scl;
    assign sda_in    = w_sda;
    assign rx_edge   = w_evt.rx_edge;
    assign tx_edge   = w_evt.tx_edge;
    assign start_det = w_evt.start_det;
    assign stop_det  = w_evt.stop_det;
    assign bus_busy  = r_busy;

endmodule

// File: tb/tb_i2c_slave_line_cond.sv
// tb/tb_i2c_slave_line_cond.sv - directed and random checks of the line conditioner against a behavioural model
module tb_i2c_slave_line_cond;

    localparam int SYNC = 2;
    localparam int FILT = 3;
    localparam int TC   = 50;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    logic scl_pad = 1'b1;
    logic sda_pad = 1'b1;
    logic scl_in, sda_in, rx_edge, tx_edge, start_det, stop_det, bus_busy, scl_timeout;

    i2c_slave_line_cond #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .TIMEOUT_CYC(TC)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .scl_pad     (scl_pad),
        .sda_pad     (sda_pad),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .rx_edge     (rx_edge),
        .tx_edge     (tx_edge),
        .start_det   (start_det),
        .stop_det    (stop_det),
        .bus_busy    (bus_busy),
        .scl_timeout (scl_timeout)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_rx = 0, cnt_tx = 0, cnt_start = 0, cnt_stop = 0, cnt_to = 0;

    // model state: pad delay lines, filtered levels, run lengths of disagreeing samples
    logic [SYNC-1:0] mp_scl = '1, mp_sda = '1;
    logic m_scl = 1'b1, m_sda = 1'b1;
    int   run_scl = 0, run_sda = 0;
    logic m_rx = 0, m_tx = 0, m_start = 0, m_stop = 0, m_busy = 0, m_to = 0;
    int   m_low = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic filt_upd(input logic sv, inout logic lvl, inout int run);
        if (sv != lvl) run++;
        else run = 0;
        if (run == FILT) begin
            lvl = ~lvl;
            run = 0;
        end
    endtask

    task automatic model_edge(input logic scl, input logic sda, input logic rstn);
        logic old_scl, old_sda, old_busy;
        if (!rstn) begin
            mp_scl = '1; mp_sda = '1;
            m_scl = 1; m_sda = 1; run_scl = 0; run_sda = 0;
            m_rx = 0; m_tx = 0; m_start = 0; m_stop = 0; m_busy = 0; m_to = 0; m_low = 0;
            return;
        end
        old_scl = m_scl; old_sda = m_sda; old_busy = m_busy;
        if (m_to) m_busy = 0;
        else if (m_start) m_busy = 1;
        else if (m_stop) m_busy = 0;
`ifdef I2C_SLAVE_SCL_TIMEOUT_EN
        if (old_busy && !old_scl) begin
            m_low++;
            m_to = (m_low == TC);
            if (m_to) m_low = 0;
        end else begin
            m_low = 0;
            m_to = 0;
        end
`else
        m_to = old_busy & 1'b0;
`endif
        filt_upd(mp_scl[SYNC-1], m_scl, run_scl);
        filt_upd(mp_sda[SYNC-1], m_sda, run_sda);
        mp_scl = {mp_scl[SYNC-2:0], scl};
        mp_sda = {mp_sda[SYNC-2:0], sda};
        m_rx    = m_scl & ~old_scl;
        m_tx    = ~m_scl & old_scl;
        m_start = m_scl & old_scl & old_sda & ~m_sda;
        m_stop  = m_scl & old_scl & ~old_sda & m_sda;
    endtask

    task automatic step(input logic scl, input logic sda, input logic rstn);
        scl_pad = scl; sda_pad = sda; presetn = rstn;
        @(posedge pclk);
        model_edge(scl, sda, rstn);
        #1;
        check_eq("outputs", {24'd0, scl_in, sda_in, rx_edge, tx_edge, start_det, stop_det, bus_busy, scl_timeout},
                 {24'd0, m_scl, m_sda, m_rx, m_tx, m_start, m_stop, m_busy, m_to});
        if (rx_edge) cnt_rx++;
        if (tx_edge) cnt_tx++;
        if (start_det) cnt_start++;
        if (stop_det) cnt_stop++;
        if (scl_timeout) cnt_to++;
    endtask

    task automatic hold(input logic scl, input logic sda, input int n);
        for (int i = 0; i < n; i++) step(scl, sda, 1'b1);
    endtask

    task automatic clr_counts();
        cnt_rx = 0; cnt_tx = 0; cnt_start = 0; cnt_stop = 0;
    endtask

    initial begin
        int first_low, start_at, busy_at, stop_at, clr_at, saw_low, to_at;
        logic d, prev_sda;

        // reset and idle
        step(1, 1, 0);
        step(1, 1, 0);
        check_eq("reset_state", {24'd0, scl_in, sda_in, rx_edge, tx_edge, start_det, stop_det, bus_busy, scl_timeout},
                 32'h0000_00C0);
        hold(1, 1, 10);
        check_eq("idle_scl_in", {31'd0, scl_in}, 32'd1);

        // START latency
        first_low = 0; start_at = 0; busy_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 1);
            if (!sda_in && first_low == 0) first_low = k;
            if (start_det) start_at = k;
            if (bus_busy && busy_at == 0) busy_at = k;
        end
        check_eq("sda_in_latency", first_low, 32'd5);
        check_eq("start_det_cycle", start_at, 32'd5);
        check_eq("busy_set_cycle", busy_at, 32'd6);

        // 9-clock byte ending with ACK low, then STOP
        clr_counts();
        prev_sda = 0;
        for (int b = 0; b < 9; b++) begin
            d = (b == 8) ? 1'b0 : 1'($urandom_range(0, 1));
            hold(0, prev_sda, 2);
            hold(0, d, 2);
            hold(1, d, 4);
            prev_sda = d;
        end
        stop_at = 0; clr_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1, 1, 1);
            if (stop_det) stop_at = k;
            if (!bus_busy && clr_at == 0) clr_at = k;
        end
        check_eq("byte_rx_edges", cnt_rx, 32'd9);
        check_eq("byte_tx_edges", cnt_tx, 32'd9);
        check_eq("byte_stop_count", cnt_stop, 32'd1);
        check_eq("busy_clear_after_stop", clr_at, stop_at + 1);

        // short glitch is filtered, FILT_LEN pulse passes
        clr_counts();
        saw_low = 0;
        hold(0, 1, 2);
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 1);
            if (!scl_in) saw_low = 1;
        end
        check_eq("glitch_scl_low", saw_low, 32'd0);
        check_eq("glitch_edges", cnt_rx + cnt_tx, 32'd0);
        hold(0, 1, 3);
        hold(1, 1, 10);
        check_eq("pulse_tx", cnt_tx, 32'd1);
        check_eq("pulse_rx", cnt_rx, 32'd1);

        // simultaneous fall of SCL and SDA
        clr_counts();
        hold(0, 0, 10);
        check_eq("simul_tx", cnt_tx, 32'd1);
        check_eq("simul_start", cnt_start, 32'd0);
        check_eq("simul_stop", cnt_stop, 32'd0);
        hold(1, 0, 10);
        hold(1, 1, 10);

`ifdef I2C_SLAVE_SCL_TIMEOUT_EN
        hold(1, 0, 8);
        first_low = 0; to_at = 0; clr_at = 0;
        for (int k = 1; k <= 80; k++) begin
            step(0, 0, 1);
            if (!scl_in && first_low == 0) first_low = k;
            if (scl_timeout && to_at == 0) to_at = k;
            if (to_at != 0 && !bus_busy && clr_at == 0) clr_at = k;
        end
        check_eq("timeout_delay", to_at - first_low, 32'd50);
        check_eq("timeout_busy_clear", clr_at, to_at + 1);
        hold(1, 0, 8);
        hold(1, 1, 8);
`endif

        // random pad activity with occasional mid-transfer reset
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0) step(1, 1, 0);
            else hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 5));
        end
        hold(1, 1, 10);

`ifndef I2C_SLAVE_SCL_TIMEOUT_EN
        check_eq("timeout_never", cnt_to, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
